// File: rtl/cursor_blink_writer.sv
// cursor_blink_writer: blinks the paint cursor by alternately writing WHITE and the saved pixel colour, restoring on move/disable
module cursor_blink_writer #(
  parameter int ADDR_W = 11,
  parameter int COLOR_W = 3,
  parameter int CNT_W = 24,
  parameter int ON_TICKS = 5000000,
  parameter int OFF_TICKS = 5000000,
  parameter logic [COLOR_W-1:0] WHITE = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  cur_addr,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic               cursor_on,
  output logic               phase_end,
  output logic               busy
);
  typedef enum logic [2:0] {IDLE, RD, ON_WR, ON_WAIT, OFF_WR, OFF_WAIT, RESTORE} state_t;
  state_t r_state, w_nxt;
  logic [ADDR_W-1:0] r_saved_addr, r_addr;
  logic [COLOR_W-1:0] r_saved_color, r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic r_req, r_we;
  logic w_ack, w_wait, w_abort, w_expire, w_issue;
  assign w_ack = r_req & mem_ack;
  assign w_wait = (r_state == ON_WAIT) || (r_state == OFF_WAIT);
  assign w_abort = w_wait & (~enable | (cur_addr != r_saved_addr));
  assign w_expire = r_cnt == ((r_state == ON_WAIT) ? CNT_W'(ON_TICKS - 1) : CNT_W'(OFF_TICKS - 1));
  // A new request starts only from a cycle with mem_req low, which also gives the idle gap after each ack
  assign w_issue = ~r_req & ((r_state == RD) || (r_state == ON_WR) || (r_state == OFF_WR) || (r_state == RESTORE));
  assign mem_req = r_req;
  assign mem_we = r_we;
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_saved_addr <= '0;
      r_saved_color <= '0;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= (w_wait && w_nxt == r_state) ? r_cnt + 1'b1 : '0;
      if (r_state != RD && w_nxt == RD) r_saved_addr <= cur_addr;
      if (r_state == RD && w_ack) r_saved_color <= mem_rdata;
      if (w_issue) begin
        r_req <= 1'b1;
        r_we <= r_state != RD;
        r_addr <= r_saved_addr;
        r_wdata <= (r_state == ON_WR) ? WHITE : r_saved_color;
      end else if (w_ack) r_req <= 1'b0;
    end
  end
  // Move/disable outranks phase expiry in the wait states
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     w_nxt = enable ? RD : IDLE;
      RD:       w_nxt = w_ack ? ON_WR : RD;
      ON_WR:    w_nxt = w_ack ? ON_WAIT : ON_WR;
      OFF_WR:   w_nxt = w_ack ? OFF_WAIT : OFF_WR;
      ON_WAIT:  w_nxt = w_abort ? RESTORE : w_expire ? OFF_WR : ON_WAIT;
      OFF_WAIT: w_nxt = w_abort ? RESTORE : w_expire ? ON_WR : OFF_WAIT;
      RESTORE:  w_nxt = w_ack ? (enable ? RD : IDLE) : RESTORE;
      default:  w_nxt = IDLE;
    endcase
  end
  always_comb begin
    phase_end = w_wait & w_expire & ~w_abort;
    cursor_on = r_state == ON_WAIT;
    busy = r_state != IDLE;
  end
endmodule

// File: tb/tb_cursor_blink_writer.sv
// tb_cursor_blink_writer: directed checks of the blink/restore sequence against a delayed-ack frame-buffer model
module tb_cursor_blink_writer;
  localparam int AW = 11;
  localparam int CW = 3;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [CW-1:0] rdata = '0;
  logic ack_resp = 1'b0, ack_force = 1'b0;
  logic mem_ack, mem_req, mem_we, cursor_on, phase_end, busy;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  int n_vec = 0, n_err = 0, ack_dly = 2, pe_cnt = 0;
  int n, pe, p0, t, w;
  logic req_seen;
  logic [CW-1:0] d;
  logic [AW+CW:0] log_q[$];
  assign mem_ack = ack_resp | ack_force;
  always #5 clk = ~clk;
  cursor_blink_writer #(.ON_TICKS(4), .OFF_TICKS(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cur_addr(cur_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(rdata), .mem_ack(mem_ack), .cursor_on(cursor_on), .phase_end(phase_end), .busy(busy)
  );
  always @(posedge clk) if (phase_end) pe_cnt <= pe_cnt + 1;
  // Frame-buffer model: acks ack_dly cycles after mem_req rises and logs each completed transaction
  initial begin
    w = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_resp) begin
        ack_resp = 1'b0;
        w = 0;
      end else if (mem_req) begin
        w++;
        if (w >= ack_dly) begin
          ack_resp = 1'b1;
          d = mem_we ? mem_wdata : '0;
          log_q.push_back({mem_we, mem_addr, d});
        end
      end else w = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic expect_txn(input string tag, input int idx, input logic we, input logic [AW-1:0] a, input logic [CW-1:0] dat);
    int k = 0;
    while (log_q.size() <= idx && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, (log_q.size() > idx) ? 32'(log_q[idx]) : 32'hdead, 32'({we, a, dat}));
  endtask
  task automatic wait_on(input string tag);
    int k = 0;
    while (!cursor_on && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(cursor_on), 32'd1);
  endtask
  task automatic count_level(input logic v, output int cnt, output int pes);
    cnt = 0;
    pes = 0;
    while (cursor_on === v && cnt < 200) begin
      cnt++;
      pes += int'(phase_end);
      @(negedge clk);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({mem_req, mem_we, mem_addr, mem_wdata, cursor_on, phase_end, busy}), 32'd0);
    rst = 1'b0;
    cur_addr = 11'h010;
    rdata = 3'b010;
    enable = 1'b1;
    expect_txn("rd_010", 0, 1'b0, 11'h010, 3'd0);
    expect_txn("white_010", 1, 1'b1, 11'h010, 3'b111);
    wait_on("on_rise1");
    count_level(1'b1, n, pe);
    chk("on_len", n, 4);
    chk("on_phase_end", pe, 1);
    count_level(1'b0, n, pe);
    chk("off_len", n, 9);
    expect_txn("off_010", 2, 1'b1, 11'h010, 3'b010);
    expect_txn("white_010b", 3, 1'b1, 11'h010, 3'b111);
    p0 = pe_cnt;
    cur_addr = 11'h011;
    rdata = 3'b101;
    expect_txn("move_restore", 4, 1'b1, 11'h010, 3'b010);
    expect_txn("move_rd_011", 5, 1'b0, 11'h011, 3'd0);
    expect_txn("move_white", 6, 1'b1, 11'h011, 3'b111);
    chk("move_no_pe", pe_cnt - p0, 0);
    wait_on("on_rise2");
    repeat (3) @(negedge clk);
    chk("expiry_pe", 32'(phase_end), 1);
    p0 = pe_cnt;
    cur_addr = 11'h012;
    rdata = 3'b001;
    #1;
    chk("prio_pe", 32'(phase_end), 0);
    expect_txn("prio_restore", 7, 1'b1, 11'h011, 3'b101);
    expect_txn("prio_rd_012", 8, 1'b0, 11'h012, 3'd0);
    expect_txn("prio_white", 9, 1'b1, 11'h012, 3'b111);
    chk("prio_no_pe", pe_cnt - p0, 0);
    wait_on("on_rise3");
    count_level(1'b1, n, pe);
    chk("on_len3", n, 4);
    expect_txn("off_012", 10, 1'b1, 11'h012, 3'b001);
    @(negedge clk);
    chk("busy_offwait", 32'(busy), 1);
    enable = 1'b0;
    expect_txn("dis_restore", 11, 1'b1, 11'h012, 3'b001);
    @(negedge clk);
    chk("dis_idle_busy", 32'(busy), 0);
    req_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      req_seen |= mem_req;
    end
    chk("dis_no_req", 32'(req_seen), 0);
    chk("dis_log", log_q.size(), 12);
    ack_dly = 10;
    cur_addr = 11'h020;
    rdata = 3'b011;
    enable = 1'b1;
    expect_txn("slow_rd_020", 12, 1'b0, 11'h020, 3'd0);
    t = 0;
    while (!(mem_req && mem_we) && t < 100) begin
      @(negedge clk);
      t++;
    end
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("slow_hold", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'({1'b1, 1'b1, 11'h020, 3'b111}));
      @(negedge clk);
    end
    expect_txn("slow_white", 13, 1'b1, 11'h020, 3'b111);
    wait_on("slow_on");
    count_level(1'b1, n, pe);
    chk("slow_on_len", n, 1);
    chk("slow_no_pe", pe, 0);
    expect_txn("slow_restore", 14, 1'b1, 11'h020, 3'b011);
    @(negedge clk);
    chk("slow_idle", 32'(busy), 0);
    cur_addr = 11'h030;
    enable = 1'b1;
    t = 0;
    while (!mem_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_req_up", 32'(mem_req), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", 32'({mem_req, mem_we, mem_addr, mem_wdata, cursor_on, phase_end, busy}), 32'd0);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_ack", 32'({busy, mem_req, cursor_on}), 32'd0);
    chk("stray_log", log_q.size(), 15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
